// File: rtl/rgb_pkg.sv
// Shared types and the dither pattern function for the RGB DAC sequencer.
// Build option: RGB_DITHER_FRAME_EN adds per-frame pattern inversion in rgb_phase.
package rgb_pkg;

  typedef enum logic [1:0] {
    DM_OFF     = 2'd0,
    DM_CHECKER = 2'd1,
    DM_LINE    = 2'd2,
    DM_COLUMN  = 2'd3
  } dither_mode_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PEND = 2'd1,
    ST_MUTE = 2'd2
  } rgb_ctrl_state_t;

  // frm is the frame parity term; tie it low when temporal dither is not built.
  function automatic logic strobe_of(dither_mode_t m, logic pix, logic line, logic frm);
    logic s;
    case (m)
      DM_CHECKER: s = ~(pix ^ line) ^ frm;
      DM_LINE:    s = ~line ^ frm;
      DM_COLUMN:  s = ~pix ^ frm;
      default:    s = 1'b1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rgb_ctrl_if.sv
// Timing/port-decoder side of the RGB sequencer: pulses and requests in, encoder controls out.
interface rgb_ctrl_if;
  logic       pixel_en;
  logic       hsync_start;
  logic       vsync_start;
  logic [1:0] dither_mode;
  logic       up_en_req;
  logic       strobe;
  logic       up_en;
  logic       mute_o;

  modport master (
    output pixel_en, hsync_start, vsync_start, dither_mode, up_en_req,
    input  strobe, up_en, mute_o
  );

  modport slave (
    input  pixel_en, hsync_start, vsync_start, dither_mode, up_en_req,
    output strobe, up_en, mute_o
  );
endinterface

// File: rtl/rgb_phase.sv
// Pixel/line/frame parity tracking and the registered dither strobe.
// Frame parity exists only when RGB_DITHER_FRAME_EN is defined.
module rgb_phase
  import rgb_pkg::*;
(
  input  logic         clk28,
  input  logic         rst_n,
  input  logic         pixel_en,
  input  logic         hsync_start,
  input  logic         vsync_start,
  input  dither_mode_t dither_mode,
  output logic         strobe
);

  logic         pix_par, line_par;
  logic         pix_nxt, line_nxt, frm_nxt;
  dither_mode_t mode_q, mode_nxt;
  logic         any_pulse;

  // Line start beats pixel, frame start beats line.
  assign pix_nxt   = hsync_start ? 1'b0 : (pix_par ^ pixel_en);
  assign line_nxt  = vsync_start ? 1'b0 : (line_par ^ hsync_start);
  assign mode_nxt  = vsync_start ? dither_mode : mode_q;
  assign any_pulse = pixel_en | hsync_start | vsync_start;

`ifdef RGB_DITHER_FRAME_EN
  logic frm_par;
  assign frm_nxt = frm_par ^ vsync_start;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) frm_par <= 1'b0;
    else        frm_par <= frm_nxt;
  end
`else
  assign frm_nxt = 1'b0;
`endif

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      pix_par  <= 1'b0;
      line_par <= 1'b0;
      mode_q   <= DM_OFF;
      strobe   <= 1'b1;
    end else begin
      pix_par  <= pix_nxt;
      line_par <= line_nxt;
      mode_q   <= mode_nxt;
      if (any_pulse)
        strobe <= strobe_of(mode_nxt, pix_nxt, line_nxt, frm_nxt);
    end
  end

endmodule

// File: rtl/rgb_ctrl.sv
// RGB DAC encoder sequencer: dither strobe plus frame-aligned ULA+ enable with mute window.
// Build option: RGB_DITHER_FRAME_EN (temporal dither, handled inside rgb_phase).
module rgb_ctrl
  import rgb_pkg::*;
#(
  parameter int MUTE_LINES         = 2,
  parameter int PEND_TIMEOUT_LINES = 320,
  parameter int LCNT_W             = 9
) (
  input  logic       clk28,
  input  logic       rst_n,
  rgb_ctrl_if.slave  bus
);

  localparam logic [LCNT_W-1:0] LCNT_MAX  = {LCNT_W{1'b1}};
  localparam logic [LCNT_W-1:0] PEND_LAST = LCNT_W'(PEND_TIMEOUT_LINES - 1);
  localparam logic [LCNT_W-1:0] MUTE_LAST = LCNT_W'((MUTE_LINES > 0) ? MUTE_LINES - 1 : 0);

  rgb_ctrl_state_t   state;
  logic              up_en_q;
  logic              mute_q;
  logic [LCNT_W-1:0] lcnt;

  rgb_phase u_phase (
    .clk28       (clk28),
    .rst_n       (rst_n),
    .pixel_en    (bus.pixel_en),
    .hsync_start (bus.hsync_start),
    .vsync_start (bus.vsync_start),
    .dither_mode (dither_mode_t'(bus.dither_mode)),
    .strobe      (bus.strobe)
  );

  assign bus.up_en  = up_en_q;
  assign bus.mute_o = mute_q;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      up_en_q <= 1'b0;
      mute_q  <= 1'b0;
      lcnt    <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.up_en_req != up_en_q) begin
            state <= ST_PEND;
            lcnt  <= '0;
          end
        end
        ST_PEND: begin
          if (bus.up_en_req == up_en_q) begin
            state <= ST_RUN;
          end else if (bus.vsync_start || (bus.hsync_start && lcnt == PEND_LAST)) begin
            // Apply at frame start, or force it if vsync has gone missing.
            up_en_q <= bus.up_en_req;
            lcnt    <= '0;
            if (MUTE_LINES != 0) begin
              state  <= ST_MUTE;
              mute_q <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end else if (bus.hsync_start && lcnt != LCNT_MAX) begin
            lcnt <= lcnt + LCNT_W'(1);
          end
        end
        ST_MUTE: begin
          if (bus.hsync_start) begin
            if (lcnt == MUTE_LAST) begin
              state  <= ST_RUN;
              mute_q <= 1'b0;
            end else if (lcnt != LCNT_MAX) begin
              lcnt <= lcnt + LCNT_W'(1);
            end
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_ctrl.sv
// Bench for rgb_ctrl: event-count reference model checked every cycle plus literal spot checks.
module tb_rgb_ctrl;

  localparam int M_MUTE = 2;
  localparam int M_PEND = 320;

  logic clk28 = 1'b0;
  logic rst_n;

  rgb_ctrl_if bus();

  rgb_ctrl dut (
    .clk28 (clk28),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #18 clk28 = ~clk28;

  int checks = 0;
  int errors = 0;

  // Reference model: counts of events since the last line/frame start.
  int m_pix = 0, m_line = 0, m_frame = 0, m_mode = 0;
  int m_up = 0, m_pend = 0, m_waited = 0, m_mute_left = 0;

  function automatic logic model_strobe();
    int  p, l;
    logic s;
    p = m_pix % 2;
    l = m_line % 2;
    case (m_mode)
      1:       s = ((p + l) % 2) == 0;
      2:       s = (l == 0);
      3:       s = (p == 0);
      default: s = 1'b1;
    endcase
`ifdef RGB_DITHER_FRAME_EN
    if (m_mode != 0 && (m_frame % 2) == 1) s = ~s;
`endif
    return s;
  endfunction

  task automatic model_update();
    int req;
    req = int'(bus.up_en_req);
    // Upgrade policy uses the state before this clock.
    if (m_mute_left > 0) begin
      if (bus.hsync_start) m_mute_left = m_mute_left - 1;
    end else if (m_pend != 0) begin
      if (req == m_up) m_pend = 0;
      else if (bus.vsync_start || (bus.hsync_start && m_waited + 1 == M_PEND)) begin
        m_up        = req;
        m_pend      = 0;
        m_mute_left = M_MUTE;
      end else if (bus.hsync_start) m_waited = m_waited + 1;
    end else if (req != m_up) begin
      m_pend   = 1;
      m_waited = 0;
    end
    if (bus.hsync_start)      m_pix = 0;
    else if (bus.pixel_en)    m_pix = m_pix + 1;
    if (bus.vsync_start)      m_line = 0;
    else if (bus.hsync_start) m_line = m_line + 1;
    if (bus.vsync_start) begin
      m_frame = m_frame + 1;
      m_mode  = int'(bus.dither_mode);
    end
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("model_strobe", bus.strobe, model_strobe());
    check("model_up_en",  bus.up_en,  logic'(m_up != 0));
    check("model_mute",   bus.mute_o, logic'(m_mute_left > 0));
  endtask

  task automatic step(input logic pe, input logic hs, input logic vs);
    bus.pixel_en    = pe;
    bus.hsync_start = hs;
    bus.vsync_start = vs;
    model_update();
    @(posedge clk28);
    #1;
    bus.pixel_en    = 1'b0;
    bus.hsync_start = 1'b0;
    bus.vsync_start = 1'b0;
    compare_model();
  endtask

  logic exp_ck [4];
  logic exp_ln [4];
  logic frm_exp;

  initial begin
    rst_n           = 1'b0;
    bus.pixel_en    = 1'b0;
    bus.hsync_start = 1'b0;
    bus.vsync_start = 1'b0;
    bus.dither_mode = 2'd0;
    bus.up_en_req   = 1'b0;
    repeat (2) @(posedge clk28);
    #1;
    check("reset_strobe", bus.strobe, 1'b1);
    check("reset_up_en",  bus.up_en,  1'b0);
    check("reset_mute",   bus.mute_o, 1'b0);
    rst_n = 1'b1;

    // Mode 0: strobe pinned high whatever pulses arrive.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      step(0, 0, 0);
    end
    step(0, 1, 0);
    step(1, 0, 0);
    step(0, 0, 1);
    check("mode0_strobe", bus.strobe, 1'b1);

    // Checkerboard latched at frame start.
    bus.dither_mode = 2'd1;
    step(0, 1, 1);
    exp_ck = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_ln = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0);
      check("checker_line0", bus.strobe, exp_ck[i]);
      step(0, 0, 0);
    end
    step(0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0);
      check("checker_line1", bus.strobe, exp_ln[i]);
      step(0, 0, 0);
    end
    bus.dither_mode = 2'd2;
    step(1, 0, 0);
    check("midframe_mode_ignored", bus.strobe, 1'b1);

    // Line mode, line 0, across two frames.
`ifdef RGB_DITHER_FRAME_EN
    frm_exp = 1'b0;
`else
    frm_exp = 1'b1;
`endif
    step(0, 0, 1);
    check("line_mode_frame_a", bus.strobe, frm_exp);
    step(0, 0, 1);
    check("line_mode_frame_b", bus.strobe, 1'b1);

    // Palette enable deferred to frame start, then two muted lines.
    bus.up_en_req = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    repeat (3) step(0, 1, 0);
    check("defer_up_en", bus.up_en,  1'b0);
    check("defer_mute",  bus.mute_o, 1'b0);
    step(0, 0, 1);
    check("switch_up_en", bus.up_en,  1'b1);
    check("switch_mute",  bus.mute_o, 1'b1);
    step(0, 1, 0);
    check("mute_line1", bus.mute_o, 1'b1);
    step(0, 1, 0);
    check("mute_end",       bus.mute_o, 1'b0);
    check("up_en_retained", bus.up_en,  1'b1);

    // Request withdrawn before frame start: nothing happens.
    step(0, 0, 0);
    bus.up_en_req = 1'b0;
    step(0, 0, 0);
    bus.up_en_req = 1'b1;
    step(0, 0, 0);
    step(0, 0, 1);
    check("revert_up_en", bus.up_en,  1'b1);
    check("revert_mute",  bus.mute_o, 1'b0);
    step(0, 1, 0);
    step(0, 1, 0);

    // No frame start: switch forced on the 320th line.
    bus.up_en_req = 1'b0;
    step(0, 0, 0);
    for (int i = 0; i < M_PEND - 1; i++) begin
      step(0, 1, 0);
      step(0, 0, 0);
    end
    check("timeout_not_yet", bus.up_en, 1'b1);
    step(0, 1, 0);
    check("timeout_up_en", bus.up_en,  1'b0);
    check("timeout_mute",  bus.mute_o, 1'b1);
    step(0, 1, 0);
    step(0, 1, 0);
    check("timeout_mute_end", bus.mute_o, 1'b0);

    // Odd line, then simultaneous line+frame start must reset line parity.
    step(0, 1, 0);
    check("odd_line_strobe", bus.strobe, 1'b0);
    step(0, 1, 1);
    check("hs_vs_line_clear", bus.strobe, frm_exp);
    step(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_ctrl.md
Name: rgb_ctrl

Overview:
Sequencer for the 2-bit RGB DAC encoder stage. Generates the per-pixel dither strobe (spatial or temporal pattern) and the ULA+ palette-enable used by the encoder. Defers palette-mode changes to a frame boundary and mutes video for a few lines across the switch. Sits between the video timing generator/port decoder and the RGB encoder, clocked by clk28.

Parameters:
MUTE_LINES, 2, lines of forced mute after an up_en change (0 = no mute)
PEND_TIMEOUT_LINES, 320, lines to wait for vsync_start before forcing a pending switch
LCNT_W, 9, width of line counters (must hold max(MUTE_LINES, PEND_TIMEOUT_LINES))

Ports:
clk28  input  1  system clock, 28 MHz
rst_n  input  1  reset, asynchronous, active-low
pixel_en  input  1  one-cycle pulse per pixel (7 MHz rate)
hsync_start  input  1  one-cycle pulse at line start
vsync_start  input  1  one-cycle pulse at frame start
dither_mode  input  2  requested dither pattern: 0 off, 1 checker, 2 line, 3 column
up_en_req  input  1  requested ULA+ palette enable (from port register)
strobe  output  1  dither phase to encoder
up_en  output  1  applied ULA+ enable to encoder
mute_o  output  1  1 = encoder output must be forced black

Behaviour:
Reset (rst_n low, async): strobe=1, up_en=0, mute_o=0, FSM=ST_RUN, pix_par=line_par=frm_par=0, mode_q=0, counters=0.
Phase tracking (all registered, every clk28):
- pix_par toggles on pixel_en; cleared on hsync_start (hsync wins over pixel_en same cycle).
- line_par toggles on hsync_start; cleared on vsync_start (vsync wins if both).
- frm_par toggles on vsync_start.
- mode_q <= dither_mode on vsync_start only; mid-frame dither_mode changes have no effect until next frame.
Strobe: registered from next-state parities and next mode_q; 1-cycle latency after the triggering pulse.
- mode 0: strobe=1 constant.
- mode 1: strobe = ~(pix_par ^ line_par).
- mode 2: strobe = ~line_par.
- mode 3: strobe = ~pix_par.
- strobe changes only in cycles with pixel_en, hsync_start or vsync_start.
up_en FSM (states ST_RUN, ST_PEND, ST_MUTE):
- ST_RUN: if up_en_req != up_en -> ST_PEND, lcnt=0.
- ST_PEND: if up_en_req == up_en (request reverted) -> ST_RUN, no change. Else on vsync_start, or on hsync_start when lcnt == PEND_TIMEOUT_LINES-1: up_en <= up_en_req, lcnt=0, -> ST_MUTE (ST_RUN if MUTE_LINES==0). Otherwise lcnt increments on hsync_start.
- ST_MUTE: mute_o=1 (registered, asserted the same edge up_en changes). lcnt increments on hsync_start; at lcnt == MUTE_LINES-1 with hsync_start -> ST_RUN, mute_o=0. up_en_req changes are ignored here and re-evaluated in ST_RUN. vsync_start has no effect on the count.
- Counters saturate; no wrap.

Optional Feature:
RGB_DITHER_FRAME_EN: when defined, strobe for modes 1-3 is additionally XORed with frm_par (pattern inverts every frame, temporal dither). When undefined, frm_par is not implemented and the pattern is static per frame.

Decomposition:
Package rgb_pkg: enum dither_mode_t (DM_OFF, DM_CHECKER, DM_LINE, DM_COLUMN); enum rgb_ctrl_state_t (ST_RUN, ST_PEND, ST_MUTE). One sub-module is natural: rgb_phase (pix/line/frame parity tracking plus strobe register). The FSM stays in rgb_ctrl.

Test Plan:
- Reset, then mode 0 and pulses: strobe stays 1, up_en=0, mute_o=0.
- dither_mode=1 latched at vsync; 4 pixels × 2 lines: strobe sequence 0,1,0,1 / 1,0,1,0 (1 clk after each pixel_en); mode change mid-frame has no effect until vsync.
- up_en_req 0→1 mid-frame: up_en stays 0 until vsync_start; then up_en=1 and mute_o=1 for exactly 2 hsync_start pulses.
- up_en_req 0→1 then back to 0 before vsync: up_en never changes, mute_o never asserted.
- No vsync after request: switch forced on the 320th hsync_start; hsync+vsync in the same cycle clears line_par to 0.
- With RGB_DITHER_FRAME_EN, mode 2: line 0 strobe=1 in frame 0, 0 in frame 1; without the macro, 1 in both frames.
